// File: rtl/div_const_pkg.sv
// Shared constants and FSM state type for the constant-divisor residue checker.
package div_const_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DIVISOR   = 5;
    localparam int unsigned R_WIDTH   = $clog2(DIVISOR);
    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_mod_step.sv
// One MSB-first residue step: next = (2*acc + bit) mod DIVISOR, given acc < DIVISOR.
module div_mod_step #(
    parameter int unsigned DIVISOR = div_const_pkg::DIVISOR,
    parameter int unsigned R_WIDTH = div_const_pkg::R_WIDTH
) (
    input  logic [R_WIDTH-1:0] acc,
    input  logic               data_bit,
    output logic [R_WIDTH-1:0] acc_next
);

    localparam logic [R_WIDTH:0] DIV_T = (R_WIDTH + 1)'(DIVISOR);

    logic [R_WIDTH:0] t;
    logic [R_WIDTH:0] diff;

    // t < 2*DIVISOR, so a single conditional subtract fully reduces it
    always_comb begin
        t        = {acc, data_bit};
        diff     = t - DIV_T;
        acc_next = (t >= DIV_T) ? diff[R_WIDTH-1:0] : t[R_WIDTH-1:0];
    end

endmodule

// File: rtl/div_16_5_res_checker.sv
// Serial golden-model checker: recomputes X mod DIVISOR one bit per clock and
// compares it with the remainder reported by the upstream divider.
module div_16_5_res_checker #(
    parameter int unsigned WIDTH     = div_const_pkg::WIDTH,
    parameter int unsigned DIVISOR   = div_const_pkg::DIVISOR,
    parameter int unsigned R_WIDTH   = div_const_pkg::R_WIDTH,
    parameter int unsigned CNT_WIDTH = div_const_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     IN_X,
    input  logic [R_WIDTH-1:0]   IN_R,
    output logic                 OUT_VALID,
    output logic [R_WIDTH-1:0]   RES_REF,
    output logic                 MISMATCH,
    output logic [CNT_WIDTH-1:0] ERR_COUNT,
    output logic                 ERR_STICKY,
    input  logic                 CLR_ERR
);

    import div_const_pkg::*;

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   x_q;
    logic [R_WIDTH-1:0] r_q;
    logic [R_WIDTH-1:0] acc_q;
    logic [R_WIDTH-1:0] acc_next;
    logic [IDX_W-1:0]   idx_q;
    logic               last_bit;
    logic               done_mis;

    div_mod_step #(
        .DIVISOR (DIVISOR),
        .R_WIDTH (R_WIDTH)
    ) u_step (
        .acc      (acc_q),
        .data_bit (x_q[idx_q]),
        .acc_next (acc_next)
    );

    assign last_bit = (idx_q == '0);
    // acc_next < DIVISOR, so an out-of-range captured remainder always mismatches
    assign done_mis = (state == RUN) && last_bit && (acc_next != r_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                OUT_VALID  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            RES_REF  <= '0;
            MISMATCH <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        x_q   <= IN_X;
                        r_q   <= IN_R;
                        acc_q <= '0;
                        idx_q <= IDX_W'(WIDTH - 1);
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q - IDX_W'(1);
                    if (last_bit) begin
                        RES_REF  <= acc_next;
                        MISMATCH <= (acc_next != r_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ERR_COUNT  <= '0;
            ERR_STICKY <= 1'b0;
        end else if (CLR_ERR) begin
            ERR_COUNT  <= '0;
            ERR_STICKY <= 1'b0;
        end else if (done_mis) begin
            ERR_STICKY <= 1'b1;
            if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + CNT_WIDTH'(1);
        end
    end

endmodule
